// File: rtl/dir_sweep_checker.sv
// ============================================================================
// Module  : dir_sweep_checker
// Purpose : Sweeps all 256 {in1,in2} vectors into dir_test and checks its
//           fifteen packed outputs against a golden model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module dir_sweep_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit STOP_ON_FAIL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  in1,
    output logic [3:0]  in2,
    input  logic [63:0] obs,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [8:0]  err_count,
    output logic [7:0]  first_err_vec,
    output logic [3:0]  first_err_field
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_last_idx    = 8'hFF;

    state_t      state_q;
    logic [3:0]  settle_cnt_q;
    logic [7:0]  idx_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [8:0]  err_count_q;
    logic [7:0]  first_err_vec_q;
    logic [3:0]  first_err_field_q;

    logic [14:0] w_mism;
    logic [3:0]  w_first;
    logic        w_any;
    logic [3:0]  w_a;
    logic [3:0]  w_b;

    assign w_a = idx_q[7:4];
    assign w_b = idx_q[3:0];

    // Expected nibble for the 4-bit fields out4..out15.
    function automatic logic [3:0] exp_nib(input int n, input logic [3:0] a,
                                           input logic [3:0] b);
        if (n <= 7) begin
            return a & b;
        end else if (n == 13 || n == 15) begin
            return {a[0], a[2], a[1], a[3]};
        end else begin
            return a;
        end
    endfunction

    always_comb begin
        w_mism    = '0;
        w_mism[0] = (obs[63:60] != w_a);
        w_mism[1] = (obs[59:56] != w_a);
        w_mism[2] = (obs[55:48] != {w_a, w_a});
        for (int n = 4; n <= 15; n++) begin
            w_mism[n-1] = (obs[47-4*(n-4) -: 4] != exp_nib(n, w_a, w_b));
        end
    end

    // Scan downward so the lowest failing field number wins.
    always_comb begin
        w_first = 4'd0;
        for (int n = 15; n >= 1; n--) begin
            if (w_mism[n-1]) begin
                w_first = 4'(n);
            end
        end
    end

    assign w_any = |w_mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            settle_cnt_q      <= 4'd0;
            idx_q             <= 8'd0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_count_q       <= 9'd0;
            first_err_vec_q   <= 8'd0;
            first_err_field_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q           <= SETTLE;
                        settle_cnt_q      <= 4'd0;
                        idx_q             <= 8'd0;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                        pass_q            <= 1'b0;
                        err_count_q       <= 9'd0;
                        first_err_vec_q   <= 8'd0;
                        first_err_field_q <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == c_settle_last) begin
                        state_q <= CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                CHECK: begin
                    if (w_any) begin
                        err_count_q <= err_count_q + 9'd1;
                        if (first_err_field_q == 4'd0) begin
                            first_err_vec_q   <= idx_q;
                            first_err_field_q <= w_first;
                        end
                    end
                    if ((w_any && STOP_ON_FAIL) || idx_q == c_last_idx) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !w_any && (err_count_q == 9'd0);
                    end else begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= 4'd0;
                        idx_q        <= idx_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in1             = idx_q[7:4];
    assign in2             = idx_q[3:0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_field = first_err_field_q;

endmodule

`default_nettype wire
